// File: rtl/dcache_nway_wb.sv
// N-way set-associative write-back data cache array with true-LRU replacement,
// a victim FIFO towards memory and a flush engine that drains every dirty line.
module dcache_nway_wb #(
    parameter int unsigned NUM_SETS = 64,
    parameter int unsigned NUM_WAYS = 2,
    parameter int unsigned TAG_W    = 55,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned VB_DEPTH = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_SETS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              st_en,
    input  logic [IDX_W-1:0]  st_idx,
    input  logic [TAG_W-1:0]  st_tag,
    input  logic [DATA_W-1:0] st_data,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [DATA_W-1:0] fill_data,
    output logic              wr_ready,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [IDX_W-1:0]  wb_idx,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_data,
    input  logic              flush_req,
    output logic              flush_busy,
    output logic              flush_done
);
    localparam int unsigned WAY_W = $clog2(NUM_WAYS);
    localparam int unsigned PTR_W = $clog2(VB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned FC_W  = IDX_W + WAY_W;

    typedef logic [NUM_WAYS-1:0][WAY_W-1:0]  age_t;
    typedef logic [NUM_WAYS-1:0][TAG_W-1:0]  tagrow_t;
    typedef logic [NUM_WAYS-1:0][DATA_W-1:0] datarow_t;
    typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

    logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
    logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];
    age_t                r_age   [NUM_SETS];
    tagrow_t             r_tag   [NUM_SETS];
    datarow_t            r_data  [NUM_SETS];

    logic [IDX_W-1:0]  r_vb_idx  [VB_DEPTH];
    logic [TAG_W-1:0]  r_vb_tag  [VB_DEPTH];
    logic [DATA_W-1:0] r_vb_data [VB_DEPTH];
    logic [PTR_W-1:0]  r_vb_wptr, r_vb_rptr;
    logic [CNT_W-1:0]  r_vb_cnt;

    state_t            r_state;
    logic [FC_W-1:0]   r_fc;
    logic              r_flush_busy, r_flush_done;

    function automatic logic [NUM_WAYS-1:0] f_match(input logic [NUM_WAYS-1:0] vld,
                                                    input tagrow_t tags,
                                                    input logic [TAG_W-1:0] tag);
        logic [NUM_WAYS-1:0] m;
        m = '0;
        for (int w = 0; w < NUM_WAYS; w++) m[w] = vld[w] && (tags[w] == tag);
        return m;
    endfunction

    function automatic logic [WAY_W-1:0] f_enc(input logic [NUM_WAYS-1:0] m);
        logic [WAY_W-1:0] v;
        v = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) if (m[w]) v = WAY_W'(w);
        return v;
    endfunction

    // Lowest free way first, otherwise the oldest way not excluded.
    function automatic logic [WAY_W-1:0] f_victim(input logic [NUM_WAYS-1:0] vld,
                                                  input age_t age,
                                                  input logic [NUM_WAYS-1:0] excl);
        logic [WAY_W-1:0] v;
        logic [WAY_W-1:0] best;
        logic             got;
        v    = '0;
        best = '0;
        got  = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!got && !excl[w] && !vld[w]) begin
                v   = WAY_W'(w);
                got = 1'b1;
            end
        end
        if (!got) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (!excl[w] && (!got || age[w] > best)) begin
                    v    = WAY_W'(w);
                    best = age[w];
                    got  = 1'b1;
                end
            end
        end
        return v;
    endfunction

    function automatic age_t f_touch(input age_t a, input logic [WAY_W-1:0] way);
        age_t r;
        r = a;
        for (int j = 0; j < NUM_WAYS; j++) if (a[j] < a[way]) r[j] = a[j] + WAY_W'(1);
        r[way] = '0;
        return r;
    endfunction

    logic [NUM_WAYS-1:0] w_rd_m, w_st_m, w_fi_excl;
    logic [WAY_W-1:0]    w_rd_way, w_st_vic, w_st_way, w_fi_vic;
    logic                w_st_hit, w_fi_hit, w_same_set, w_st_acc, w_fi_acc;
    logic                w_push_a, w_push_b, w_push_f, w_pop, w_fs_dirty, w_fs_adv;
    logic [IDX_W-1:0]    w_fs_set, w_p0_idx;
    logic [WAY_W-1:0]    w_fs_way;
    logic [TAG_W-1:0]    w_p0_tag;
    logic [DATA_W-1:0]   w_p0_data;
    logic [CNT_W-1:0]    w_npush;
    age_t                w_age_rd, w_age_fi, w_age_st;

    assign w_rd_m   = f_match(r_valid[rd_idx], r_tag[rd_idx], rd_tag);
    assign rd_valid = |w_rd_m;
    assign w_rd_way = f_enc(w_rd_m);
    assign rd_data  = rd_valid ? r_data[rd_idx][w_rd_way] : '0;

    assign wr_ready = (r_state == StIdle) && (r_vb_cnt <= CNT_W'(VB_DEPTH - 2));

    assign w_st_m   = f_match(r_valid[st_idx], r_tag[st_idx], st_tag);
    assign w_st_hit = |w_st_m;
    assign w_st_vic = f_victim(r_valid[st_idx], r_age[st_idx], '0);
    assign w_st_way = w_st_hit ? f_enc(w_st_m) : w_st_vic;
    assign w_st_acc = st_en && wr_ready;

    // The fill must never land on the way the same-cycle store owns.
    assign w_same_set = w_st_acc && (st_idx == fill_idx);
    assign w_fi_hit   = |f_match(r_valid[fill_idx], r_tag[fill_idx], fill_tag);
    assign w_fi_excl  = w_same_set ? (NUM_WAYS'(1) << w_st_way) : '0;
    assign w_fi_vic   = f_victim(r_valid[fill_idx], r_age[fill_idx], w_fi_excl);
    assign w_fi_acc   = fill_en && wr_ready && !w_fi_hit && !(w_same_set && st_tag == fill_tag);

    assign w_push_a = w_st_acc && !w_st_hit && r_valid[st_idx][w_st_vic] && r_dirty[st_idx][w_st_vic];
    assign w_push_b = w_fi_acc && r_valid[fill_idx][w_fi_vic] && r_dirty[fill_idx][w_fi_vic];

    assign w_fs_set   = r_fc[FC_W-1:WAY_W];
    assign w_fs_way   = r_fc[WAY_W-1:0];
    assign w_fs_dirty = r_valid[w_fs_set][w_fs_way] && r_dirty[w_fs_set][w_fs_way];
    assign w_push_f   = (r_state == StScan) && w_fs_dirty && (r_vb_cnt != CNT_W'(VB_DEPTH));
    assign w_fs_adv   = (r_state == StScan) && (!w_fs_dirty || w_push_f);

    // Store victim occupies the first slot; fill victim follows it.
    assign w_p0_idx  = w_push_a ? st_idx : w_push_b ? fill_idx : w_fs_set;
    assign w_p0_tag  = w_push_a ? r_tag[st_idx][w_st_vic] :
                       w_push_b ? r_tag[fill_idx][w_fi_vic] : r_tag[w_fs_set][w_fs_way];
    assign w_p0_data = w_push_a ? r_data[st_idx][w_st_vic] :
                       w_push_b ? r_data[fill_idx][w_fi_vic] : r_data[w_fs_set][w_fs_way];
    assign w_npush   = CNT_W'(w_push_a) + CNT_W'(w_push_b) + CNT_W'(w_push_f);
    assign w_pop     = wb_valid && wb_ready;

    assign wb_valid = (r_vb_cnt != '0);
    assign wb_idx   = r_vb_idx[r_vb_rptr];
    assign wb_tag   = r_vb_tag[r_vb_rptr];
    assign wb_data  = r_vb_data[r_vb_rptr];

    // LRU updates chain read -> fill -> store so the later NBA carries all touches.
    assign w_age_rd = f_touch(r_age[rd_idx], w_rd_way);
    assign w_age_fi = f_touch((rd_valid && rd_idx == fill_idx) ? w_age_rd : r_age[fill_idx],
                              w_fi_vic);
    assign w_age_st = f_touch((w_fi_acc && fill_idx == st_idx) ? w_age_fi :
                              (rd_valid && rd_idx == st_idx) ? w_age_rd : r_age[st_idx],
                              w_st_way);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) r_age[s][w] <= WAY_W'(w);
            end
            r_vb_wptr <= '0;
            r_vb_rptr <= '0;
            r_vb_cnt  <= '0;
        end else begin
            if (rd_valid) r_age[rd_idx] <= w_age_rd;
            if (w_fi_acc) begin
                r_age[fill_idx]             <= w_age_fi;
                r_valid[fill_idx][w_fi_vic] <= 1'b1;
                r_dirty[fill_idx][w_fi_vic] <= 1'b0;
            end
            if (w_st_acc) begin
                r_age[st_idx]             <= w_age_st;
                r_valid[st_idx][w_st_way] <= 1'b1;
                r_dirty[st_idx][w_st_way] <= 1'b1;
            end
            if (w_push_f) r_dirty[w_fs_set][w_fs_way] <= 1'b0;
            r_vb_wptr <= r_vb_wptr + PTR_W'(w_npush);
            r_vb_rptr <= r_vb_rptr + PTR_W'(w_pop);
            r_vb_cnt  <= r_vb_cnt + w_npush - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_st_acc) begin
            r_tag[st_idx][w_st_way]  <= st_tag;
            r_data[st_idx][w_st_way] <= st_data;
        end
        if (w_fi_acc) begin
            r_tag[fill_idx][w_fi_vic]  <= fill_tag;
            r_data[fill_idx][w_fi_vic] <= fill_data;
        end
        if (w_npush != '0) begin
            r_vb_idx[r_vb_wptr]  <= w_p0_idx;
            r_vb_tag[r_vb_wptr]  <= w_p0_tag;
            r_vb_data[r_vb_wptr] <= w_p0_data;
        end
        if (w_push_a && w_push_b) begin
            r_vb_idx[r_vb_wptr + PTR_W'(1)]  <= fill_idx;
            r_vb_tag[r_vb_wptr + PTR_W'(1)]  <= r_tag[fill_idx][w_fi_vic];
            r_vb_data[r_vb_wptr + PTR_W'(1)] <= r_data[fill_idx][w_fi_vic];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_fc         <= '0;
            r_flush_busy <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (flush_req) begin
                        r_state      <= StScan;
                        r_fc         <= '0;
                        r_flush_busy <= 1'b1;
                    end
                end
                StScan: begin
                    if (w_fs_adv) begin
                        r_fc <= r_fc + FC_W'(1);
                        if (r_fc == '1) r_state <= StDone;
                    end
                end
                StDone: begin
                    if (r_vb_cnt == '0) begin
                        r_state      <= StIdle;
                        r_flush_busy <= 1'b0;
                        r_flush_done <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign flush_busy = r_flush_busy;
    assign flush_done = r_flush_done;
endmodule

// File: tb/tb_dcache_nway_wb.sv
// Directed bench for dcache_nway_wb (4-way); victim beats are checked against a
// queue of expected write-backs filled as the evicting stimulus is issued.
module tb_dcache_nway_wb;
    localparam int unsigned NS = 64;
    localparam int unsigned NW = 4;
    localparam int unsigned TW = 55;
    localparam int unsigned DW = 64;
    localparam int unsigned VD = 4;
    localparam int unsigned IW = 6;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } wb_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [IW-1:0] rd_idx, st_idx, fill_idx, wb_idx;
    logic [TW-1:0] rd_tag, st_tag, fill_tag, wb_tag;
    logic [DW-1:0] rd_data, st_data, fill_data, wb_data;
    logic          rd_valid, st_en, fill_en, wr_ready, wb_valid, wb_ready;
    logic          flush_req, flush_busy, flush_done;

    wb_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    logic seen;

    always #5 clock = ~clock;

    dcache_nway_wb #(
        .NUM_SETS(NS), .NUM_WAYS(NW), .TAG_W(TW), .DATA_W(DW), .VB_DEPTH(VD)
    ) dut (
        .clock(clock), .reset(reset),
        .rd_idx(rd_idx), .rd_tag(rd_tag), .rd_data(rd_data), .rd_valid(rd_valid),
        .st_en(st_en), .st_idx(st_idx), .st_tag(st_tag), .st_data(st_data),
        .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_data(fill_data),
        .wr_ready(wr_ready),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_idx(wb_idx), .wb_tag(wb_tag),
        .wb_data(wb_data),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                            input logic [DW-1:0] data);
        wb_t e;
        e.idx  = idx;
        e.tag  = tag;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Called at the negedge: a handshake seen here completes at the next posedge.
    task automatic chk_wb();
        wb_t e;
        if (wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", 64'(wb_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_idx", 64'(wb_idx), 64'(e.idx));
                chk("wb_tag", 64'(wb_tag), 64'(e.tag));
                chk("wb_data", wb_data, e.data);
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        chk_wb();
        @(posedge clock);
        #1;
    endtask

    task automatic do_fill(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                           input logic [DW-1:0] data);
        fill_en = 1'b1; fill_idx = idx; fill_tag = tag; fill_data = data;
        step();
        fill_en = 1'b0;
    endtask

    task automatic do_store(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                            input logic [DW-1:0] data);
        st_en = 1'b1; st_idx = idx; st_tag = tag; st_data = data;
        step();
        st_en = 1'b0;
    endtask

    task automatic do_both(input logic [IW-1:0] idx, input logic [TW-1:0] stag,
                           input logic [DW-1:0] sdata, input logic [TW-1:0] ftag,
                           input logic [DW-1:0] fdata);
        st_en = 1'b1; st_idx = idx; st_tag = stag; st_data = sdata;
        fill_en = 1'b1; fill_idx = idx; fill_tag = ftag; fill_data = fdata;
        step();
        st_en = 1'b0; fill_en = 1'b0;
    endtask

    task automatic rd_touch(input logic [IW-1:0] idx, input logic [TW-1:0] tag);
        rd_idx = idx; rd_tag = tag;
        step();
        rd_tag = '1;
    endtask

    // Samples a read without letting it reach a clock edge, so LRU is untouched.
    task automatic rd_chk(input string name, input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                          input logic ev, input logic [DW-1:0] ed);
        rd_idx = idx; rd_tag = tag;
        @(negedge clock);
        chk({name, "_valid"}, 64'(rd_valid), 64'(ev));
        chk({name, "_data"}, rd_data, ed);
        rd_tag = '1;
        chk_wb();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; st_en = 1'b0; fill_en = 1'b0; flush_req = 1'b0; wb_ready = 1'b0;
        rd_idx = '0; rd_tag = '1; st_idx = '0; st_tag = '0; st_data = '0;
        fill_idx = '0; fill_tag = '0; fill_data = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_flush_busy", 64'(flush_busy), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);

        // Basic fill then hit.
        do_fill(5, 55'h10, 64'hAA);
        rd_chk("fill5", 5, 55'h10, 1'b1, 64'hAA);
        chk("fill5_wb_valid", 64'(wb_valid), 64'd0);

        // LRU: read-touch tag 1 so tag 2 becomes oldest.
        for (int t = 1; t <= 4; t++) do_fill(0, 55'(t), 64'h100 + 64'(t));
        rd_touch(0, 55'h1);
        do_fill(0, 55'h5, 64'h105);
        chk("lru_no_wb", 64'(wb_valid), 64'd0);
        rd_chk("lru_t1", 0, 55'h1, 1'b1, 64'h101);
        rd_chk("lru_t2", 0, 55'h2, 1'b0, 64'h0);
        rd_chk("lru_t3", 0, 55'h3, 1'b1, 64'h103);
        rd_chk("lru_t4", 0, 55'h4, 1'b1, 64'h104);
        rd_chk("lru_t5", 0, 55'h5, 1'b1, 64'h105);

        // Dirty eviction of a stored line.
        do_store(3, 55'h7, 64'h1);
        do_fill(3, 55'h8, 64'h8);
        do_fill(3, 55'h9, 64'h9);
        do_fill(3, 55'hA, 64'hA);
        push_exp(3, 55'h7, 64'h1);
        do_fill(3, 55'hB, 64'hB);
        chk("evict_wb_valid", 64'(wb_valid), 64'd1);
        wb_ready = 1'b1;
        step();
        chk("evict_wb_popped", 64'(wb_valid), 64'd0);
        rd_chk("evict_t7", 3, 55'h7, 1'b0, 64'h0);
        rd_chk("evict_t11", 3, 55'hB, 1'b1, 64'hB);

        // Backpressure: three dirty victims leave fewer than two free slots.
        wb_ready = 1'b0;
        for (int t = 0; t < 4; t++) do_store(4, 55'h20 + 55'(t), 64'h200 + 64'(t));
        for (int t = 0; t < 3; t++) begin
            push_exp(4, 55'h20 + 55'(t), 64'h200 + 64'(t));
            do_fill(4, 55'h30 + 55'(t), 64'h300 + 64'(t));
            chk($sformatf("bp_wr_ready_%0d", t), 64'(wr_ready), (t == 2) ? 64'd0 : 64'd1);
        end
        do_store(6, 55'h40, 64'h4444);
        rd_chk("bp_ignored", 6, 55'h40, 1'b0, 64'h0);
        wb_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (wr_ready) seen = 1'b1;
        end
        chk("bp_wr_ready_back", 64'(seen), 64'd1);
        for (int c = 0; c < 20 && wb_valid; c++) step();
        chk("bp_drained", 64'(wb_valid), 64'd0);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Same-cycle store and fill.
        do_both(2, 55'h4, 64'h55, 55'h4, 64'h99);
        rd_chk("both_same", 2, 55'h4, 1'b1, 64'h55);
        do_both(7, 55'h50, 64'h5, 55'h51, 64'h6);
        rd_chk("both_st", 7, 55'h50, 1'b1, 64'h5);
        rd_chk("both_fi", 7, 55'h51, 1'b1, 64'h6);
        do_fill(2, 55'h60, 64'h60);
        do_fill(2, 55'h61, 64'h61);
        do_fill(2, 55'h62, 64'h62);
        push_exp(2, 55'h4, 64'h55);
        do_fill(2, 55'h63, 64'h63);

        // Flush: dirty lines drain in set order.
        do_store(0, 55'h1, 64'h700);
        do_store(9, 55'h90, 64'h900);
        do_store(63, 55'h3F, 64'h3F00);
        rd_chk("pre_flush_hit", 0, 55'h1, 1'b1, 64'h700);
        chk("pre_flush_queue", 64'(exp_q.size()), 64'd0);
        push_exp(0, 55'h1, 64'h700);
        push_exp(4, 55'h23, 64'h203);
        push_exp(7, 55'h50, 64'h5);
        push_exp(9, 55'h90, 64'h900);
        push_exp(63, 55'h3F, 64'h3F00);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        chk("flush_busy", 64'(flush_busy), 64'd1);
        chk("flush_wr_ready", 64'(wr_ready), 64'd0);
        rd_chk("flush_rd", 63, 55'h3F, 1'b1, 64'h3F00);
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            step();
            if (flush_done) seen = 1'b1;
        end
        chk("flush_done_seen", 64'(seen), 64'd1);
        step();
        chk("flush_done_pulse", 64'(flush_done), 64'd0);
        chk("flush_busy_after", 64'(flush_busy), 64'd0);
        chk("flush_queue_empty", 64'(exp_q.size()), 64'd0);
        rd_chk("flush_kept0", 0, 55'h1, 1'b1, 64'h700);
        rd_chk("flush_kept9", 9, 55'h90, 1'b1, 64'h900);

        // Second flush finds nothing dirty.
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            step();
            if (flush_done) seen = 1'b1;
        end
        chk("flush2_done_seen", 64'(seen), 64'd1);
        step();
        chk("flush2_wb_valid", 64'(wb_valid), 64'd0);
        chk("flush2_wr_ready", 64'(wr_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dcache_nway_wb.md
Name: dcache_nway_wb

Overview:
- Parametrised N-way set-associative write-back data cache array; successor to the 2-way write-through-style Dcache array.
- Sits between the cache controller and the memory interface.
- Adds configurable sets, ways and widths, true-LRU replacement, dirty tracking, and a victim (write-back) FIFO with valid/ready handshake.
- Adds a flush state machine that drains all dirty lines.

Parameters:
- NUM_SETS, 64, number of sets; power of 2, 4..256.
- NUM_WAYS, 2, associativity; power of 2, 2..8.
- TAG_W, 55, tag width.
- DATA_W, 64, line width.
- VB_DEPTH, 4, victim FIFO entries; power of 2, minimum 2.
- IDX_W, log2(NUM_SETS), derived; not overridden.

Ports:
- clock  input  1  single clock, posedge.
- reset  input  1  asynchronous active-low reset; 0 = reset.
- rd_idx  input  IDX_W  read set index.
- rd_tag  input  TAG_W  read tag.
- rd_data  output  DATA_W  hit data; 0 when no hit.
- rd_valid  output  1  read hit.
- st_en  input  1  store from processor.
- st_idx  input  IDX_W  store set index.
- st_tag  input  TAG_W  store tag.
- st_data  input  DATA_W  store data.
- fill_en  input  1  line fill from memory (load miss).
- fill_idx  input  IDX_W  fill set index.
- fill_tag  input  TAG_W  fill tag.
- fill_data  input  DATA_W  fill data.
- wr_ready  output  1  st_en/fill_en accepted this cycle.
- wb_valid  output  1  victim FIFO head valid.
- wb_ready  input  1  memory accepts head.
- wb_idx  output  IDX_W  victim set index.
- wb_tag  output  TAG_W  victim tag.
- wb_data  output  DATA_W  victim data.
- flush_req  input  1  start flush; sampled in IDLE only.
- flush_busy  output  1  flush in progress.
- flush_done  output  1  one-cycle pulse at flush completion.

Behaviour:
- Reset (async assert, sync-free deassert):
  - All valid and dirty bits 0; ages of way w = w.
  - Victim FIFO empty; FSM in IDLE.
  - Outputs: rd_valid=0, rd_data=0, wb_valid=0, flush_busy=0, flush_done=0, wr_ready=1.
  - Data and tag arrays are not reset.
- Read:
  - Combinational; hit = any way valid with matching tag; rd_data = that way's data.
  - A hit touches LRU at the edge.
  - Same-cycle writes are not forwarded; the new value is visible next cycle.
- Accept conditions:
  - wr_ready = (FSM==IDLE) and FIFO free slots >= 2.
  - st_en/fill_en with wr_ready=0 are ignored; the controller holds and retries.
- Store:
  - Hit: overwrite data, set dirty, touch.
  - Miss: allocate victim way, write tag/data, valid=1, dirty=1, touch.
- Fill:
  - Miss: allocate victim way, dirty=0, touch.
  - Fill that hits an existing line: ignored.
  - Fill with same idx and tag as an accepted same-cycle store: dropped; store wins.
- Victim selection: lowest-index invalid way; else way with age NUM_WAYS-1.
- Same-set store miss and fill miss in one cycle, different tags:
  - Store takes the victim.
  - Fill takes the next-oldest way, never the store's way.
- Eviction: if the displaced line is valid and dirty, push {idx, old tag, old data} into the victim FIFO at the same edge.
- LRU:
  - Touching way w sets age[w]=0 and increments every age < old age[w].
  - Touch order within a cycle: read, then fill, then store; the store ends most recent.
  - Ages stay a permutation of 0..NUM_WAYS-1.
- Victim FIFO:
  - Pop when wb_valid & wb_ready.
  - Push and pop in the same cycle is allowed.
  - Head is registered; a push to an empty FIFO gives wb_valid=1 the next cycle.
  - Pointers wrap modulo VB_DEPTH.
  - Order is strictly FIFO.
- Flush FSM: IDLE -> SCAN -> DONE -> IDLE.
  - IDLE -> SCAN: on flush_req; set/way counter := 0; flush_busy=1.
  - SCAN, per cycle: examine one (set, way).
    - Valid and dirty: if FIFO not full, push it, clear dirty, advance the counter; else hold the counter.
    - Otherwise: advance the counter.
    - Lines stay valid.
  - SCAN -> DONE: after the last (set, way) is processed.
  - DONE: wait until the FIFO is empty, then pulse flush_done=1 for one cycle and return to IDLE.
  - Reads are serviced throughout the flush.
  - flush_req while busy is ignored.
- Reset mid-flush or with a non-empty FIFO: all state returns to reset values; pending victims are lost.

Test Plan:
- Reset, then fill set 5 with tag 0x10 data 0xAA -> next cycle rd(5, 0x10) gives rd_valid=1, rd_data=0xAA; wb_valid stays 0.
- NUM_WAYS=4: fill tags 1,2,3,4 into set 0, read tag 1, fill tag 5 -> tag 2 evicted (clean, no wb); tags 1,3,4,5 hit.
- Store tag 7 data 0x1 to set 3 (2-way), fill tags 8 then 9 -> dirty tag 7 evicted; wb_valid=1 with wb_idx=3, wb_tag=7, wb_data=0x1; pops on wb_ready.
- Hold wb_ready=0 and evict dirty lines until wr_ready=0 (VB_DEPTH=4: after 3 pushes) -> further st_en is ignored; raising wb_ready frees slots and wr_ready returns to 1.
- Same cycle: st(2, tag 4, 0x55) and fill(2, tag 4, 0x99) -> rd(2, 4) = 0x55 and line is dirty; same-set different-tag misses land in two distinct ways.
- Dirty lines in sets 0, 9, 63; pulse flush_req with wb_ready=1 -> three wb beats in set order, flush_done pulses once, lines still hit; a second flush produces zero beats.
